// File: rtl/priority_arbiter8.sv
// -----------------------------------------------------------------------------
// priority_arbiter8
//
// Eight-requester arbiter with a bounded grant hold time. A winner is chosen
// from IDLE, latched for the whole grant, and released on done, on loss of
// its own request, on en dropping, or after MAX_HOLD consecutive cycles. Every
// release passes through one IDLE cycle, so back-to-back grants are always
// separated by exactly one idle cycle.
//
// Optional feature (compile-time macro):
//   ROUND_ROBIN_EN  - rotate priority with a 3-bit last-grant pointer so the
//                     most recent grantee has lowest priority. Without it the
//                     winner is the highest set index of req (bit 7 highest).
//
// Parameters:
//   MAX_HOLD  - maximum consecutive grant cycles, legal range 2..256
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst      in   asynchronous active-high reset
//   en       in   arbiter enable
//   req      in   [7:0] request vector, bit i = requester i
//   done     in   current grantee releases the resource
//   gnt      out  [7:0] one-hot grant, registered
//   gnt_id   out  [2:0] binary index of the grantee, registered (0 when idle)
//   valid    out  grant active, registered
//   timeout  out  one-cycle pulse on a release forced by the hold limit
// -----------------------------------------------------------------------------
module priority_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       valid,
    output logic       timeout
);

    // Counter only ever needs to reach MAX_HOLD-1.
    localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q,    state_d;
    logic [7:0]       gnt_q,      gnt_d;
    logic [2:0]       gnt_id_q,   gnt_id_d;
    logic             valid_q,    valid_d;
    logic             timeout_q,  timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [2:0]       winner;
    logic             hold_at_max;
    logic             release_grant;
    logic             own_req;

`ifdef ROUND_ROBIN_EN
    logic [2:0]       last_q, last_d;

    // Search last-1, last-2, ... wrapping, ending at last itself, so the most
    // recent grantee is considered only when nobody else is asking.
    function automatic logic [2:0] pick_rr(input logic [7:0] r,
                                           input logic [2:0] last);
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last - 3'(k);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        winner = pick_rr(req, last_q);
    end
`else
    // Ascending scan: the last set bit seen is the highest index, which wins.
    function automatic logic [2:0] pick_fixed(input logic [7:0] r);
        logic [2:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                w = 3'(i);
            end
        end
        return w;
    endfunction

    always_comb begin
        winner = pick_fixed(req);
    end
`endif

    // Release conditions are evaluated against the latched grantee only;
    // other requesters have no influence while a grant is held.
    assign own_req       = req[gnt_id_q];
    assign hold_at_max   = (hold_cnt_q == HOLD_LAST);
    assign release_grant = done | ~own_req | ~en | hold_at_max;

    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        valid_d    = valid_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
`ifdef ROUND_ROBIN_EN
        last_d     = last_q;
`endif

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (en && (req != 8'h00)) begin
                    state_d  = GRANT;
                    gnt_d    = 8'h01 << winner;
                    gnt_id_d = winner;
                    valid_d  = 1'b1;
`ifdef ROUND_ROBIN_EN
                    last_d   = winner;
`endif
                end else begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    valid_d  = 1'b0;
                end
            end

            GRANT: begin
                if (release_grant) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    valid_d    = 1'b0;
                    hold_cnt_d = '0;
                    // Pulse only when the hold limit is the sole cause.
                    timeout_d  = hold_at_max & ~done & own_req & en;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                gnt_id_d   = '0;
                valid_d    = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_priority_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_priority_arbiter8
//
// Directed bench for priority_arbiter8 (MAX_HOLD = 16). Works for both the
// default fixed-priority build and the ROUND_ROBIN_EN build; only the
// alternation sequence expects different grant ids.
// -----------------------------------------------------------------------------
module tb_priority_arbiter8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    priority_arbiter8 #(.MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic t);
        check({tag, ".gnt"}, gnt, g);
        check({tag, ".gnt_id"}, {5'b0, gnt_id}, {5'b0, id});
        check({tag, ".valid"}, {7'b0, valid}, {7'b0, v});
        check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [2:0] exp_id;
        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // First arbitration on the first edge after reset release.
        rst = 1'b0;
        en  = 1'b1;
        req = 8'b0010_0110;
        step();
        chk_out("first_grant", 8'h20, 3'd5, 1'b1, 1'b0);

        // Hold requester 5 alone: 16 grant cycles, then a timeout idle cycle.
        req = 8'h20;
        for (int i = 1; i < 16; i++) begin
            step();
            check("hold.valid", {7'b0, valid}, 8'd1);
            check("hold.gnt_id", {5'b0, gnt_id}, 8'd5);
        end
        step();
        chk_out("timeout_idle", 8'h00, 3'd0, 1'b0, 1'b1);
        step();
        chk_out("regrant", 8'h20, 3'd5, 1'b1, 1'b0);

        // done on the same cycle the counter reaches 15: normal release.
        repeat (15) step();
        check("cnt15.valid", {7'b0, valid}, 8'd1);
        done = 1'b1;
        step();
        chk_out("done_at_max", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        step();
        chk_out("regrant2", 8'h20, 3'd5, 1'b1, 1'b0);

        // en dropped mid-grant, then all requests with en low.
        en = 1'b0;
        step();
        chk_out("en_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("en_low_ff", 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Single requesters, ignoring newcomers, release on own request drop.
        en  = 1'b1;
        req = 8'h01;
        step();
        chk_out("req0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h81;
        step();
        chk_out("ignore_higher", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h10;
        step();
        chk_out("drop0", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("req4", 8'h10, 3'd4, 1'b1, 1'b0);
        req = 8'h03;
        step();
        chk_out("drop4", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("pick1", 8'h02, 3'd1, 1'b1, 1'b0);

        // Grant requester 3, then asynchronous reset in mid-cycle.
        req = 8'h08;
        step();
        chk_out("drop1", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("req3", 8'h08, 3'd3, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h81;
        rst = 1'b0;

        // Requesters 7 and 0 held, done pulsed on every grant.
        for (int g = 0; g < 4; g++) begin
            exp_id = (RR && (g % 2 == 1)) ? 3'd0 : 3'd7;
            step();
            chk_out("alt_grant", 8'h01 << exp_id, exp_id, 1'b1, 1'b0);
            done = 1'b1;
            step();
            chk_out("alt_idle", 8'h00, 3'd0, 1'b0, 1'b0);
            done = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priority_arbiter8.md
PRIORITY_ARBITER8 -- requirements
Module: priority_arbiter8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16: maximum number of consecutive cycles one grant is held, legal range 2..256.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: arbiter enable.
REQ-005 The block SHALL have port req, input, 8 bits: request vector; bit i is requester i.
REQ-006 The block SHALL have port done, input, 1 bit: the current grantee releases the resource.
REQ-007 The block SHALL have port gnt, output, 8 bits: one-hot grant vector, registered.
REQ-008 The block SHALL have port gnt_id, output, 3 bits: binary index of the granted requester, registered.
REQ-009 The block SHALL have port valid, output, 1 bit: a grant is active, registered.
REQ-010 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on forced release, registered.

Function
REQ-011 The FSM SHALL have two states, IDLE and GRANT.
REQ-012 In IDLE, if en=1 and req!=0, the next state SHALL be GRANT, with the winner latched into gnt/gnt_id and valid=1 on the next edge (1-cycle latency).
REQ-013 In IDLE, if en=0 or req=0, the FSM SHALL stay in IDLE with gnt=0, gnt_id=0 and valid=0.
REQ-014 Fixed-priority winner selection SHALL be the highest set index of req: bit 7 highest, bit 0 lowest.
REQ-015 While in GRANT, gnt, gnt_id and valid SHALL hold steady, and requests from other requesters SHALL be ignored.
REQ-016 GRANT SHALL return to IDLE on the next edge on any of these conditions: done=1; req[gnt_id]=0; en=0; the hold counter reaching MAX_HOLD-1.
REQ-017 On return to IDLE, gnt, gnt_id and valid SHALL be 0 for at least one cycle; back-to-back grants SHALL therefore be separated by exactly one idle cycle.
REQ-018 The hold counter SHALL be 0 on the first GRANT cycle, increment once per GRANT cycle, clear in IDLE, and be wide enough to hold MAX_HOLD-1.
REQ-019 timeout SHALL pulse high for exactly one cycle, coincident with the first IDLE cycle, only when release was caused by the hold counter alone.
REQ-020 If done=1 or the request drops in the same cycle the counter reaches MAX_HOLD-1, the block SHALL release normally and timeout SHALL stay 0.
REQ-021 gnt SHALL always be one-hot when valid=1, zero when valid=0, and equal to 1<<gnt_id.
REQ-022 Unknown/X-free: gnt_id SHALL never be driven to Z; it SHALL be 0 when idle.

Reset
REQ-023 When rst=1, the block SHALL force state=IDLE, gnt=0, gnt_id=0, valid=0, timeout=0, hold counter=0 and the last-grant pointer=0, immediately and independent of clk.
REQ-024 Reset asserted mid-grant SHALL drop the grant without a timeout pulse.
REQ-025 After rst deasserts, the first arbitration SHALL be possible on the first rising edge.

Configuration
REQ-026 With macro ROUND_ROBIN_EN defined, the block SHALL keep a 3-bit last-grant pointer, updated on every grant.
REQ-027 With ROUND_ROBIN_EN defined, the search order SHALL be last-1, last-2, ... wrapping 0->7, ending at last, so the most recent grantee has lowest priority.
REQ-028 With ROUND_ROBIN_EN defined, the reset pointer value 0 SHALL make the first search order 7..0, identical to fixed priority.
REQ-029 Without ROUND_ROBIN_EN, the block SHALL use pure fixed priority per REQ-014, and no pointer SHALL exist.

Verification
REQ-030 Bench SHALL drive req=8'b0010_0110 with en=1 from IDLE -> next edge: gnt=8'b0010_0000, gnt_id=5, valid=1.
REQ-031 Bench SHALL hold req[5]=1 and done=0 with MAX_HOLD=16 -> valid high for 16 cycles, then 1 idle cycle with timeout=1, then re-grant.
REQ-032 Bench SHALL test the no-macro build with req=8'b1000_0001 constantly held and done pulsed every grant -> gnt_id always 7; ROUND_ROBIN_EN build -> gnt_id alternates 7,0,7,0.
REQ-033 Bench SHALL assert rst for 1 cycle mid-grant (gnt_id=3) -> gnt=0 and valid=0 immediately (asynchronously), with timeout=0.
REQ-034 Bench SHALL drop en during GRANT -> valid=0 next edge; req=8'hFF with en=0 -> no grant.
REQ-035 Bench SHALL set done=1 on the same cycle the counter reaches 15 -> release with timeout=0.
